// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle MIPS control sequencer with stage strobes
//
// Steps one instruction at a time through IF/ID/REG/EX/MEM/WB/JU/BR.
// The path is chosen from the opcode sampled in ID.
//
// Optional feature (macro MEM_HANDSHAKE_EN):
//   undefined - IF and MEM each last MEM_LAT+1 enabled cycles; mem_ready is ignored.
//   defined   - IF and MEM hold until mem_ready=1; MEM_LAT is ignored.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   top_en       run enable; low freezes all state and silences every output pulse
//   opcode[5:0]  MIPS opcode, sampled on the ID exit edge
//   mem_ready    memory completion (handshake build only)
//   IF..BR       one-hot stage strobes, gated by top_en
//   state[3:0]   current state code
//   instr_done   high on the last cycle of each retired instruction
//   illegal      high on the ID cycle of an unknown opcode
//   instr_cnt    retired-instruction count, wraps modulo 2^CNT_W
module control_sequencer #(
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             top_en,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IF,
  output logic             ID,
  output logic             REG,
  output logic             EX,
  output logic             MEM,
  output logic             WB,
  output logic             JU,
  output logic             BR,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_IF = 4'd1, S_ID = 4'd2, S_REG = 4'd3, S_EX = 4'd4,
    S_MEM  = 4'd5, S_WB = 4'd6, S_JU = 4'd7, S_BR  = 4'd8
  } state_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  state_t     st_q;
  logic [3:0] wait_q;
  logic [5:0] op_q;
  logic       hold_done;

`ifdef MEM_HANDSHAKE_EN
  // The wait counter still exists but is always reloaded with zero.
  localparam logic [3:0] RELOAD = 4'd0;
  logic unused_wait;
  assign hold_done   = mem_ready;
  assign unused_wait = |wait_q;
`else
  localparam logic [3:0] RELOAD = 4'(MEM_LAT);
  logic unused_mem_ready;
  assign hold_done        = (wait_q == 4'd0);
  assign unused_mem_ready = mem_ready;
`endif

  // Only IF and MEM can stretch; every other state leaves after one enabled cycle.
  logic stage_exit;
  logic is_final;
  logic op_known;

  assign stage_exit = (st_q == S_IF || st_q == S_MEM) ? hold_done : 1'b1;
  assign is_final   = (st_q == S_WB) || (st_q == S_JU) || (st_q == S_BR) ||
                      (st_q == S_MEM && op_q == OP_SW);
  assign op_known   = (opcode == OP_R) || (opcode[5:3] == 3'b001) ||
                      (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                      (opcode == OP_J) || (opcode == OP_JAL);

  // The outputs decode the registered state. They are gated by top_en so that
  // a freeze silences them in the same cycle.
  assign IF         = top_en && (st_q == S_IF);
  assign ID         = top_en && (st_q == S_ID);
  assign REG        = top_en && (st_q == S_REG);
  assign EX         = top_en && (st_q == S_EX);
  assign MEM        = top_en && (st_q == S_MEM);
  assign WB         = top_en && (st_q == S_WB);
  assign JU         = top_en && (st_q == S_JU);
  assign BR         = top_en && (st_q == S_BR);
  assign state      = st_q;
  assign instr_done = top_en && is_final && stage_exit;
  assign illegal    = top_en && (st_q == S_ID) && !op_known;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= S_IDLE;
      wait_q    <= 4'd0;
      op_q      <= 6'd0;
      instr_cnt <= '0;
    end else if (top_en) begin
      if (is_final && stage_exit)
        instr_cnt <= instr_cnt + CNT_W'(1);
      case (st_q)
        S_IDLE: begin
          st_q   <= S_IF;
          wait_q <= RELOAD;
        end
        S_IF: begin
          if (hold_done)
            st_q <= S_ID;
          else if (wait_q != 4'd0)
            wait_q <= wait_q - 4'd1;
        end
        S_ID: begin
          op_q <= opcode;
          if (opcode == OP_J || opcode == OP_JAL) begin
            st_q <= S_JU;
          end else if (op_known) begin
            st_q <= S_REG;
          end else begin
            st_q   <= S_IF;
            wait_q <= RELOAD;
          end
        end
        S_REG: st_q <= (op_q == OP_BEQ || op_q == OP_BNE) ? S_BR : S_EX;
        S_EX: begin
          if (op_q == OP_LW || op_q == OP_SW) begin
            st_q   <= S_MEM;
            wait_q <= RELOAD;
          end else begin
            st_q <= S_WB;
          end
        end
        S_MEM: begin
          if (hold_done) begin
            if (op_q == OP_SW) begin
              st_q   <= S_IF;
              wait_q <= RELOAD;
            end else begin
              st_q <= S_WB;
            end
          end else if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end
        end
        // The final states and the unused codes 9-15 all restart at IF.
        default: begin
          st_q   <= S_IF;
          wait_q <= RELOAD;
        end
      endcase
    end
  end

endmodule
